// File: rtl/swu_pkg.sv
// Shared definitions for the sliding-window asymmetric circular buffer
// (read and write controllers).
//   clog2  : constant-foldable ceil(log2) for parameter derivation
//   occ_t  : occupancy counter type for the default buffer depth
package swu_pkg;

  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  localparam int SWU_SIZEB = 1024;
  localparam int SWU_ADDRW = clog2(SWU_SIZEB);

  // One extra bit so a completely full buffer (occ == SIZEB) is representable.
  typedef logic [SWU_ADDRW:0] occ_t;

endpackage

// File: rtl/swu_out_fifo2.sv
// Two-entry registered output FIFO (shift style: the head is always a
// register, so dout has no combinational path from din).
// Ports:
//   clk, rst_n   clock, async active-low reset
//   clear        sync flush to empty, data to zero
//   push, din    write an element
//   pop          remove the head element
//   dout         head element
//   cnt          occupancy 0..2
module swu_out_fifo2 #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);

  logic [W-1:0] head, tail;

  assign dout = head;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else if (clear) begin
      head <= '0;
      tail <= '0;
      cnt  <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) head <= din;
          else             tail <= din;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          // Head advances; with one entry the stale tail is never visible
          // because cnt drops to zero.
          head <= tail;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) head <= din;
          else begin
            head <= tail;
            tail <= din;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/swu_ram_read_ctrl.sv
// Read-side controller for the sliding-window asymmetric circular buffer.
// Reads RAM port B as a circular FIFO, tracks element occupancy from
// write-commit pulses, returns free-word credits to the writer and hides
// the 1-cycle RAM latency behind a 2-entry output FIFO (AXI-Stream out).
// Ports:
//   ap_clk, ap_rst_n       clock, async active-low reset
//   clear                  sync flush of pointers, counts and output FIFO
//   wr_commit              one port-A word (RATIO elements) committed
//   free_words             port-A words the writer may still commit
//   overflow               sticky: commit attempted with no credit
//   ram_enaB, ram_addrB    RAM port B read request
//   ram_doB                RAM port B data, valid the cycle after ram_enaB
//   out_tdata/tvalid/tready  AXI-Stream output
module swu_ram_read_ctrl
  import swu_pkg::*;
#(
  parameter int WIDTHB     = 4,
  parameter int SIZEB      = SWU_SIZEB,
  parameter int ADDRWIDTHB = clog2(SIZEB),
  parameter int RATIO      = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  clear,
  input  logic                  wr_commit,
  output logic [ADDRWIDTHB:0]   free_words,
  output logic                  overflow,
  output logic                  ram_enaB,
  output logic [ADDRWIDTHB-1:0] ram_addrB,
  input  logic [WIDTHB-1:0]     ram_doB,
  output logic [WIDTHB-1:0]     out_tdata,
  output logic                  out_tvalid,
  input  logic                  out_tready
);

  localparam int                  RatioLog2 = clog2(RATIO);
  localparam logic [ADDRWIDTHB:0] SizeB     = (ADDRWIDTHB+1)'(SIZEB);
  localparam logic [ADDRWIDTHB:0] RatioB    = (ADDRWIDTHB+1)'(RATIO);
  localparam logic [ADDRWIDTHB:0] OneB      = (ADDRWIDTHB+1)'(1);

  logic [ADDRWIDTHB:0]   occ, occNext, freeElems;
  logic [ADDRWIDTHB-1:0] rdPtr;
  logic                  inflight, issue, pop, commitOk;
  logic [1:0]            fifoCnt;
  logic [2:0]            pending;

  // Credits are whole port-A words; a partially drained word gives no credit.
  assign freeElems  = SizeB - occ;
  assign free_words = freeElems >> RatioLog2;
  assign commitOk   = wr_commit && (free_words != '0);

  // Elements already claimed on the output side after this cycle's pop.
  // Keeping this below 2 before issuing is what bounds the FIFO at 2.
  assign pop     = out_tvalid && out_tready;
  assign pending = {1'b0, fifoCnt} + {2'b00, inflight} - {2'b00, pop};
  assign issue   = (occ != '0) && (pending < 3'd2);

  assign ram_enaB   = issue;
  assign ram_addrB  = rdPtr;
  assign out_tvalid = (fifoCnt != 2'd0);

  always_comb begin
    occNext = occ;
    if (commitOk) occNext = occNext + RatioB;
    if (issue)    occNext = occNext - OneB;
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      occ      <= '0;
      rdPtr    <= '0;
      inflight <= 1'b0;
      overflow <= 1'b0;
    end else if (clear) begin
      occ      <= '0;
      rdPtr    <= '0;
      inflight <= 1'b0;
      overflow <= 1'b0;
    end else begin
      occ      <= occNext;
      inflight <= issue;
      // Natural wrap of the ADDRWIDTHB-bit pointer gives modulo SIZEB.
      if (issue) rdPtr <= rdPtr + ADDRWIDTHB'(1);
      if (wr_commit && (free_words == '0)) overflow <= 1'b1;
    end
  end

  // inflight marks that ram_doB carries the element read last cycle.
  swu_out_fifo2 #(.W(WIDTHB)) uOutFifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .clear (clear),
    .push  (inflight),
    .din   (ram_doB),
    .pop   (pop),
    .dout  (out_tdata),
    .cnt   (fifoCnt)
  );

endmodule
